// File: rtl/aes_key_schedule.sv
// rtl/aes_key_schedule.sv - AES-128 key expansion with an 11-entry round-key store
//
// aes_key_expand_round: one combinational AES-128 key-expansion round.
//   key[127:0]     previous round key (w0 in [127:96] .. w3 in [31:0])
//   count[3:0]     round index 0..9, selects Rcon 01..36
//   key_out[127:0] next round key
//
// aes_key_schedule: accepts a cipher key, expands it over ten cycles into
// eleven round keys, and serves registered random-access reads of them.
//   clk, rst              clock, synchronous active-high reset
//   key_in, key_valid     cipher key offer
//   key_ready             key can be taken this cycle (IDLE or DONE)
//   rk_rd_en, rk_addr     round-key read request, index 0..10
//   rk_data, rk_valid     registered read data and its one-cycle valid
//   rk_err                one-cycle pulse for a rejected read
//   busy                  expansion in progress
//   keys_ready            all eleven round keys are stored and readable

module aes_key_expand_round (
    input  logic [127:0] key,
    input  logic [3:0]   count,
    output logic [127:0] key_out
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box computed as multiplicative inverse (x^254, which maps 0 to 0)
    // followed by the affine transform, so no 256-entry table is needed.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] x2, x4, x8, x16, x32, x64, x128, inv;
        x2   = gf_mul(x, x);
        x4   = gf_mul(x2, x2);
        x8   = gf_mul(x4, x4);
        x16  = gf_mul(x8, x8);
        x32  = gf_mul(x16, x16);
        x64  = gf_mul(x32, x32);
        x128 = gf_mul(x64, x64);
        inv  = gf_mul(gf_mul(gf_mul(x2, x4), gf_mul(x8, x16)),
                      gf_mul(gf_mul(x32, x64), x128));
        return inv
             ^ {inv[6:0], inv[7]}
             ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]}
             ^ 8'h63;
    endfunction

    logic [7:0]  rcon;
    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot_w3;
    logic [31:0] sub_w3;
    logic [31:0] t;
    logic [31:0] w4, w5, w6, w7;

    always_comb begin
        rcon = 8'h00;
        case (count)
            4'd0:    rcon = 8'h01;
            4'd1:    rcon = 8'h02;
            4'd2:    rcon = 8'h04;
            4'd3:    rcon = 8'h08;
            4'd4:    rcon = 8'h10;
            4'd5:    rcon = 8'h20;
            4'd6:    rcon = 8'h40;
            4'd7:    rcon = 8'h80;
            4'd8:    rcon = 8'h1b;
            4'd9:    rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    assign w0     = key[127:96];
    assign w1     = key[95:64];
    assign w2     = key[63:32];
    assign w3     = key[31:0];
    assign rot_w3 = {w3[23:0], w3[31:24]};
    assign sub_w3 = {sbox(rot_w3[31:24]), sbox(rot_w3[23:16]),
                     sbox(rot_w3[15:8]),  sbox(rot_w3[7:0])};
    assign t      = sub_w3 ^ {rcon, 24'h000000};
    assign w4     = w0 ^ t;
    assign w5     = w1 ^ w4;
    assign w6     = w2 ^ w5;
    assign w7     = w3 ^ w6;
    assign key_out = {w4, w5, w6, w7};

endmodule

module aes_key_schedule (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] key_in,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic         rk_rd_en,
    input  logic [3:0]   rk_addr,
    output logic [127:0] rk_data,
    output logic         rk_valid,
    output logic         rk_err,
    output logic         busy,
    output logic         keys_ready
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] EXPAND = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    logic [1:0]   state;
    logic [3:0]   cnt;
    logic [127:0] cur;
    logic [127:0] key_out;
    logic         accept;
    logic         rd_ok;

    logic         rk_we;
    logic [3:0]   rk_widx;
    logic [127:0] rk_wdata;
    logic [127:0] rk_mem [0:10];

    aes_key_expand_round u_round (
        .key     (cur),
        .count   (cnt),
        .key_out (key_out)
    );

    assign key_ready = (state != EXPAND);
    assign busy      = (state == EXPAND);
    assign accept    = key_valid && key_ready;
    // keys_ready is the registered flag, so a read in the accept cycle
    // still sees the previous key set (or is rejected if there is none).
    assign rd_ok     = rk_rd_en && keys_ready && (rk_addr <= 4'd10);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            cur        <= 128'd0;
            keys_ready <= 1'b0;
        end else begin
            case (state)
                EXPAND: begin
                    cur <= key_out;
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd9) begin
                        state      <= DONE;
                        keys_ready <= 1'b1;
                    end
                end
                default: begin
                    if (accept) begin
                        cur        <= key_in;
                        cnt        <= 4'd0;
                        state      <= EXPAND;
                        keys_ready <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Storage write port: entry 0 on accept, entry cnt+1 on each expand step.
    always_comb begin
        rk_we    = 1'b0;
        rk_widx  = 4'd0;
        rk_wdata = key_out;
        if (!rst) begin
            if (state == EXPAND) begin
                rk_we    = 1'b1;
                rk_widx  = cnt + 4'd1;
                rk_wdata = key_out;
            end else if (accept) begin
                rk_we    = 1'b1;
                rk_widx  = 4'd0;
                rk_wdata = key_in;
            end
        end
    end

    // Round-key RAM is deliberately not reset; keys_ready guards its contents.
    always_ff @(posedge clk) begin
        if (rk_we) begin
            rk_mem[rk_widx] <= rk_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rk_data  <= 128'd0;
            rk_valid <= 1'b0;
            rk_err   <= 1'b0;
        end else if (rk_rd_en) begin
            if (rd_ok) begin
                rk_data  <= rk_mem[rk_addr];
                rk_valid <= 1'b1;
                rk_err   <= 1'b0;
            end else begin
                rk_data  <= 128'd0;
                rk_valid <= 1'b0;
                rk_err   <= 1'b1;
            end
        end else begin
            rk_valid <= 1'b0;
            rk_err   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_aes_key_schedule.sv
// tb/tb_aes_key_schedule.sv - randomized self-checking bench for aes_key_schedule

module tb_aes_key_schedule;

    typedef logic [10:0][127:0] keyset_t;

    localparam logic [127:0] K1      = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K1_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] K1_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] K0_RK1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] K0_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] key_in;
    logic         key_valid;
    logic         key_ready;
    logic         rk_rd_en;
    logic [3:0]   rk_addr;
    logic [127:0] rk_data;
    logic         rk_valid;
    logic         rk_err;
    logic         busy;
    logic         keys_ready;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    logic [7:0] sbox_t [256];

    keyset_t      m_keys;
    int           m_left = 0;
    logic         m_kr = 1'b0;
    logic         m_valid = 1'b0;
    logic         m_err = 1'b0;
    logic [127:0] m_data = 128'd0;

    aes_key_schedule dut (
        .clk        (clk),
        .rst        (rst),
        .key_in     (key_in),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .rk_rd_en   (rk_rd_en),
        .rk_addr    (rk_addr),
        .rk_data    (rk_data),
        .rk_valid   (rk_valid),
        .rk_err     (rk_err),
        .busy       (busy),
        .keys_ready (keys_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = (x << 1) ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box from its definition: brute-force inverse, then bitwise affine map.
    initial begin
        for (int x = 0; x < 256; x++) begin
            logic [7:0] b = 8'h00;
            logic [7:0] s;
            logic [7:0] c = 8'h63;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = b[i] ^ b[(i + 4) % 8] ^ b[(i + 5) % 8] ^ b[(i + 6) % 8]
                     ^ b[(i + 7) % 8] ^ c[i];
            sbox_t[x] = s;
        end
    end

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    // Word-array expansion w[0..43] straight from the AES key-schedule recurrence.
    function automatic keyset_t expand(input logic [127:0] k);
        logic [31:0] w [44];
        logic [7:0]  rc = 8'h01;
        keyset_t     ks;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            if (i % 4 == 0) begin
                w[i] = w[i - 4] ^ sub_word({w[i - 1][23:0], w[i - 1][31:24]}) ^ {rc, 24'h0};
                rc   = gmul(rc, 8'h02);
            end else begin
                w[i] = w[i - 4] ^ w[i - 1];
            end
        end
        for (int r = 0; r < 11; r++)
            ks[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
        return ks;
    endfunction

    // Reference model: a countdown of remaining expansion cycles plus the
    // complete key set computed at accept time.
    always @(posedge clk) begin
        if (rst) begin
            m_left  <= 0;
            m_kr    <= 1'b0;
            m_valid <= 1'b0;
            m_err   <= 1'b0;
            m_data  <= 128'd0;
        end else begin
            if (rk_rd_en) begin
                if (m_kr && rk_addr <= 4'd10) begin
                    m_data  <= m_keys[rk_addr];
                    m_valid <= 1'b1;
                    m_err   <= 1'b0;
                end else begin
                    m_data  <= 128'd0;
                    m_valid <= 1'b0;
                    m_err   <= 1'b1;
                end
            end else begin
                m_valid <= 1'b0;
                m_err   <= 1'b0;
            end
            if (m_left != 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) m_kr <= 1'b1;
            end else if (key_valid) begin
                m_keys <= expand(key_in);
                m_left <= 10;
                m_kr   <= 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("key_ready",  128'(key_ready),  128'(m_left == 0));
            check("busy",       128'(busy),       128'(m_left != 0));
            check("keys_ready", 128'(keys_ready), 128'(m_kr));
            check("rk_valid",   128'(rk_valid),   128'(m_valid));
            check("rk_err",     128'(rk_err),     128'(m_err));
            check("rk_data",    rk_data,          m_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #2;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic quiet();
        key_valid = 1'b0;
        rk_rd_en  = 1'b0;
        rk_addr   = 4'd0;
        rst       = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        key_in = 128'd0;
        key_valid = 1'b0;
        rk_rd_en = 1'b0;
        rk_addr = 4'd0;
        tick();
        chk_en = 1'b1;
        tick();
        quiet();

        // Known vector, with a rejected read during expansion.
        key_in = K1;
        key_valid = 1'b1;
        tick();
        check("pin_k1_rk0",  m_keys[0],  K1);
        check("pin_k1_rk1",  m_keys[1],  K1_RK1);
        check("pin_k1_rk10", m_keys[10], K1_RK10);
        quiet();
        ticks(3);
        rk_rd_en = 1'b1;
        rk_addr = 4'd3;
        tick();
        quiet();
        ticks(8);

        // Back-to-back reads of every entry, then out-of-range addresses.
        for (int a = 0; a <= 10; a++) begin
            rk_rd_en = 1'b1;
            rk_addr = 4'(a);
            tick();
        end
        check("lit_k1_rk10", rk_data, K1_RK10);
        rk_addr = 4'd11;
        tick();
        rk_addr = 4'd15;
        tick();
        quiet();
        tick();

        // All-zero key accepted in DONE with a same-cycle read of the old set.
        key_in = 128'd0;
        key_valid = 1'b1;
        rk_rd_en = 1'b1;
        rk_addr = 4'd1;
        tick();
        check("lit_old_rk1", rk_data, K1_RK1);
        check("pin_k0_rk1",  m_keys[1],  K0_RK1);
        check("pin_k0_rk10", m_keys[10], K0_RK10);
        quiet();
        ticks(10);
        rk_rd_en = 1'b1;
        rk_addr = 4'd10;
        tick();
        check("lit_k0_rk10", rk_data, K0_RK10);
        quiet();
        tick();

        // key_valid held through expansion with a different key.
        key_in = K1;
        key_valid = 1'b1;
        tick();
        key_in = {$urandom, $urandom, $urandom, $urandom};
        ticks(12);
        quiet();
        ticks(11);

        // Read and accept in the same IDLE cycle.
        rst = 1'b1;
        tick();
        quiet();
        key_in = K1;
        key_valid = 1'b1;
        rk_rd_en = 1'b1;
        rk_addr = 4'd0;
        tick();
        quiet();

        // Reset sampled at the fifth expansion edge, then a fresh key.
        ticks(4);
        rst = 1'b1;
        tick();
        quiet();
        tick();
        key_in = K1;
        key_valid = 1'b1;
        tick();
        quiet();
        ticks(10);
        rk_rd_en = 1'b1;
        rk_addr = 4'd10;
        tick();
        check("lit_rst_rk10", rk_data, K1_RK10);
        quiet();

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 299) == 0);
            key_valid = ($urandom_range(0, 14) == 0);
            key_in    = {$urandom, $urandom, $urandom, $urandom};
            rk_rd_en  = 1'($urandom_range(0, 1));
            rk_addr   = 4'($urandom_range(0, 15));
            tick();
        end
        quiet();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
